// File: rtl/cordic_tanh_exp.sv
// Post-processing stage for a hyperbolic CORDIC: derives e^theta and e^-theta from cosh/sinh
// and computes tanh = sinh/cosh with a bit-serial restoring divider.
module cordic_tanh_exp #(
   parameter int W    = 16,
   parameter int FRAC = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] cosh,
   input  logic [W-1:0] sinh,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] tanh,
   output logic [W-1:0] exp_pos,
   output logic [W-1:0] exp_neg,
   output logic         sat,
   output logic         err,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);
   localparam logic [W-1:0]  QMAX = {{(W-FRAC){1'b0}}, {FRAC{1'b1}}};

   typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [W:0]      rem_q;
   logic [W-1:0]    dvd_q, quo_q, div_q;
   logic            neg_q, ovf_q;
   logic [W-1:0]    tanh_q, exp_pos_q, exp_neg_q;
   logic            sat_q, err_q;

   logic            accept_s, cos_pos_s, last_s, ge_s, big_s;
   logic [W:0]      sum_s, diff_s, pos_c_s, neg_c_s, rem_sh_s, rem_nx_s;
   logic [W-1:0]    mag_s, quo_nx_s, tmag_s, tres_s;
   logic [2*W-1:0]  dvd_full_s;

   // Returns {clamped, value}: W+1-bit sum squeezed into W bits.
   function automatic logic [W:0] clamp_fn(input logic [W:0] v);
      if (v[W] != v[W-1]) clamp_fn = {1'b1, v[W], {(W-1){~v[W]}}};
      else                clamp_fn = {1'b0, v[W-1:0]};
   endfunction

   // Accept-edge arithmetic and one restoring-division step.
   always_comb begin
      accept_s   = in_valid && (state_q == IDLE);
      cos_pos_s  = !cosh[W-1] && (cosh != {W{1'b0}});
      sum_s      = {cosh[W-1], cosh} + {sinh[W-1], sinh};
      diff_s     = {cosh[W-1], cosh} - {sinh[W-1], sinh};
      pos_c_s    = clamp_fn(sum_s);
      neg_c_s    = clamp_fn(diff_s);
      mag_s      = sinh[W-1] ? (~sinh + {{(W-1){1'b0}}, 1'b1}) : sinh;
      dvd_full_s = {{W{1'b0}}, mag_s} << FRAC;
      rem_sh_s   = {rem_q[W-1:0], dvd_q[W-1]};
      ge_s       = rem_sh_s >= {1'b0, div_q};
      rem_nx_s   = ge_s ? (rem_sh_s - {1'b0, div_q}) : rem_sh_s;
      quo_nx_s   = {quo_q[W-2:0], ge_s};
      last_s     = (cnt_q == LAST);
      big_s      = ovf_q || (quo_nx_s > QMAX);
      tmag_s     = big_s ? QMAX : quo_nx_s;
      tres_s     = neg_q ? (~tmag_s + {{(W-1){1'b0}}, 1'b1}) : tmag_s;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; a non-positive cosh skips the divider entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_s) state_d = cos_pos_s ? DIV : DONE;
                  else          state_d = IDLE;
         DIV:     if (last_s)   state_d = DONE;
                  else          state_d = DIV;
         DONE:    if (out_ready) state_d = IDLE;
                  else           state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register.
   always_comb begin
      in_ready  = (state_q == IDLE) && !rst;
      out_valid = (state_q == DONE);
   end

   // Datapath: capture on accept, iterate in DIV, results held until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= {CW{1'b0}};
         rem_q     <= {(W+1){1'b0}};
         dvd_q     <= {W{1'b0}};
         quo_q     <= {W{1'b0}};
         div_q     <= {W{1'b0}};
         neg_q     <= 1'b0;
         ovf_q     <= 1'b0;
         tanh_q    <= {W{1'b0}};
         exp_pos_q <= {W{1'b0}};
         exp_neg_q <= {W{1'b0}};
         sat_q     <= 1'b0;
         err_q     <= 1'b0;
      end else if (accept_s) begin
         cnt_q     <= {CW{1'b0}};
         rem_q     <= {1'b0, dvd_full_s[2*W-1:W]};
         dvd_q     <= dvd_full_s[W-1:0];
         quo_q     <= {W{1'b0}};
         div_q     <= cosh;
         neg_q     <= sinh[W-1];
         ovf_q     <= dvd_full_s[2*W-1:W] >= cosh;
         tanh_q    <= {W{1'b0}};
         exp_pos_q <= pos_c_s[W-1:0];
         exp_neg_q <= neg_c_s[W-1:0];
         sat_q     <= pos_c_s[W] | neg_c_s[W];
         err_q     <= !cos_pos_s;
      end else if (state_q == DIV) begin
         cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
         rem_q <= rem_nx_s;
         dvd_q <= {dvd_q[W-2:0], 1'b0};
         quo_q <= quo_nx_s;
         if (last_s) begin
            tanh_q <= tres_s;
            sat_q  <= sat_q | big_s;
         end else begin
            tanh_q <= tanh_q;
            sat_q  <= sat_q;
         end
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign tanh    = tanh_q;
   assign exp_pos = exp_pos_q;
   assign exp_neg = exp_neg_q;
   assign sat     = sat_q;
   assign err     = err_q;

endmodule

// File: tb/tb_cordic_tanh_exp.sv
// Directed, table-driven bench for cordic_tanh_exp: result values, latency,
// back-pressure hold and mid-division reset abort.
module tb_cordic_tanh_exp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cosh = 16'h0000, sinh = 16'h0000;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, sat, err, out_valid;
   logic [15:0] tanh, exp_pos, exp_neg;

   int checks = 0;
   int failures = 0;

   cordic_tanh_exp #(.W(16), .FRAC(14)) dut (
      .clk(clk), .rst(rst), .cosh(cosh), .sinh(sinh), .in_valid(in_valid),
      .in_ready(in_ready), .tanh(tanh), .exp_pos(exp_pos), .exp_neg(exp_neg),
      .sat(sat), .err(err), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] c, s, t, ep, en;
      logic        sa, er;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Presents one operand pair, waits for the result and checks it; leaves out_ready low.
   task automatic issue(input logic [15:0] c, input logic [15:0] s, output int lat);
      @(negedge clk);
      chk("in_ready_before_accept", in_ready, 1);
      cosh = c; sinh = s; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid_after_drain", out_valid, 0);
      chk("in_ready_after_drain", in_ready, 1);
   endtask

   initial begin
      int lat;
      logic [15:0] held;

      //            cosh      sinh      tanh      exp_pos   exp_neg   sat   err
      vecs[0]  = '{16'h482B, 16'h2159, 16'h1D92, 16'h6984, 16'h26D2, 1'b0, 1'b0};
      vecs[1]  = '{16'h482B, 16'hDEA7, 16'hE26E, 16'h26D2, 16'h6984, 1'b0, 1'b0};
      vecs[2]  = '{16'h4000, 16'h0000, 16'h0000, 16'h4000, 16'h4000, 1'b0, 1'b0};
      vecs[3]  = '{16'h6AC1, 16'h5570, 16'h3338, 16'h7FFF, 16'h1551, 1'b1, 1'b0};
      vecs[4]  = '{16'h0000, 16'h1234, 16'h0000, 16'h1234, 16'hEDCC, 1'b0, 1'b1};
      vecs[5]  = '{16'h2000, 16'h3000, 16'h3FFF, 16'h5000, 16'hF000, 1'b1, 1'b0};
      vecs[6]  = '{16'h2000, 16'hD000, 16'hC001, 16'hF000, 16'h5000, 1'b1, 1'b0};
      vecs[7]  = '{16'h7FFF, 16'h8000, 16'hC001, 16'hFFFF, 16'h7FFF, 1'b1, 1'b0};
      vecs[8]  = '{16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b1};
      vecs[9]  = '{16'h0001, 16'h0100, 16'h3FFF, 16'h0101, 16'hFF01, 1'b1, 1'b0};
      vecs[10] = '{16'h4000, 16'hFFFF, 16'hFFFF, 16'h3FFF, 16'h4001, 1'b0, 1'b0};

      // reset state
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_tanh", tanh, 0);
      chk("rst_exp_pos", exp_pos, 0);
      chk("rst_exp_neg", exp_neg, 0);
      chk("rst_sat_err", {sat, err}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("in_ready_after_release", in_ready, 1);

      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].c, vecs[i].s, lat);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].er ? 0 : 16);
         chk($sformatf("v%0d_out_valid", i), out_valid, 1);
         chk($sformatf("v%0d_tanh", i), tanh, vecs[i].t);
         chk($sformatf("v%0d_exp_pos", i), exp_pos, vecs[i].ep);
         chk($sformatf("v%0d_exp_neg", i), exp_neg, vecs[i].en);
         chk($sformatf("v%0d_sat", i), sat, vecs[i].sa);
         chk($sformatf("v%0d_err", i), err, vecs[i].er);
         drain();
      end

      // back-pressure: hold 5 cycles with a competing input offered
      issue(16'h482B, 16'h2159, lat);
      chk("bp_latency", lat, 16);
      held = tanh;
      @(negedge clk);
      cosh = 16'h4000; sinh = 16'h0000; in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_tanh_stable", tanh, held);
         chk("bp_exp_pos_stable", exp_pos, 16'h6984);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk("bp_leave_not_accepted", in_ready, 1);
      chk("bp_leave_out_valid", out_valid, 0);
      chk("bp_tanh_kept", tanh, 16'h1D92);

      // reset mid-division aborts the operation
      @(negedge clk);
      cosh = 16'h482B; sinh = 16'h2159; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("abort_in_ready_busy", in_ready, 0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_in_ready_rst", in_ready, 0);
      chk("abort_out_valid_rst", out_valid, 0);
      chk("abort_tanh_rst", tanh, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_in_ready_release", in_ready, 1);
      begin
         logic seen;
         seen = 1'b0;
         repeat (20) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
         end
         chk("abort_no_result", seen, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
